clk_seq_ctrl: RTL and testbench
===============================

# clk_seq_ctrl

Clock-enable sequencer for testbench clock generators. Drives one enable per generator instance and turns the enabled generators on in ascending index order, with a fixed cycle gap between steps. It turns them off in descending order with the same gap, so testbench clock domains start and stop in a controlled, staggered way. It sits beside a bank of clock generators and is driven by a free-running reference clock in the bench top level.

## Interface
- NUM_CLKS, default 4: number of controlled clock generators (1–32).
- GAP, default 8: cycles between successive enable/disable steps (≥1).
- clk  in  1: reference clock; all logic on rising edge.
- rst  in  1: synchronous, active-high reset.
- start_req  in  1: single-cycle request to ramp up.
- stop_req  in  1: single-cycle request to ramp down.
- mask  in  NUM_CLKS: domains participating; sampled only when start_req is accepted.
- en  out  NUM_CLKS: registered per-generator enable; reset 0.
- busy  out  1: ramp in progress; reset 0.
- done  out  1: one-cycle pulse on ramp completion; reset 0.
- err  out  1: present only with CLK_SEQ_ERR_EN (see Configuration); reset 0.

## Operation
- States: OFF (reset), RAMP_UP, ON, RAMP_DOWN.
- OFF + start_req:
  - latch mask into act_mask; go to RAMP_UP at the lowest set index.
  - If act_mask == 0, go directly to ON and pulse done; en stays 0.
- RAMP_UP:
  - Set en[i] for the current index i, then load the gap counter with GAP-1.
  - When the counter reaches 0, advance to the next set bit of act_mask. Cleared bits are skipped and cost no cycles.
  - After the highest set bit is enabled, go to ON.
- ON + stop_req: go to RAMP_DOWN at the highest currently set en bit.
- RAMP_DOWN:
  - Clear en[i], wait GAP cycles, then move to the next lower set bit.
  - After the lowest bit is cleared, go to OFF.
- stop_req during RAMP_UP (abort):
  - Enter RAMP_DOWN at the next edge, starting from the highest currently set en bit.
  - The gap counter reloads.
  - The done pulse is issued when OFF is reached.
- Dropped requests (no effect):
  - start_req in RAMP_UP, ON or RAMP_DOWN.
  - stop_req in OFF or RAMP_DOWN.
- start_req and stop_req in the same cycle: stop_req takes priority in all states. In OFF both are therefore dropped.
- busy = state is RAMP_UP or RAMP_DOWN.
- Gap counter width: $clog2(GAP+1). It never wraps and saturates at 0.

## Timing
- Request sampled at edge 0. With k set bits in act_mask:
  - en of the j-th set bit (j = 0..k-1) rises at edge 1 + j*GAP.
  - busy is high from edge 1 through edge 1 + (k-1)*GAP.
  - At edge 2 + (k-1)*GAP: state becomes ON, busy falls, done pulses for one cycle.
- Ramp-down is symmetric: en bits fall at edges 1 + j*GAP in descending index order, and done pulses when OFF is entered.
- k = 1: en at edge 1, done at edge 2.
- rst asserted in any state: at the next edge en = 0, busy = 0, done = 0, state = OFF, act_mask = 0. There is no staggered shutdown on reset.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- CLK_SEQ_ERR_EN defined:
  - err port exists.
  - err pulses for one cycle, one edge after any dropped request, including a simultaneous start/stop where start is discarded.
- CLK_SEQ_ERR_EN not defined: err port and its logic are absent; dropped requests are silently ignored.

## Test plan
- NUM_CLKS=4, GAP=8, mask=4'b1111, start at edge 0 → en bits rise at edges 1, 9, 17, 25; done at edge 26; busy high on edges 1–25.
- mask=4'b1010, start → en[1] at edge 1, en[3] at edge 9, done at edge 10. Then stop → en[3] falls first, en[1] falls GAP cycles later, done pulses when OFF is entered.
- mask=0, start → done at edge 1, en stays 0, state ON. Then stop → RAMP_DOWN with no bits to clear, OFF, done.
- Stop at edge 10 during a full-mask ramp-up (en = 4'b0011) → en[1] falls at edge 11, en[0] at edge 19, done at edge 20, no further enables.
- rst at edge 12 mid-ramp-up → en = 0, busy = 0, done = 0 at edge 13. A subsequent start restarts from the lowest index.
- With CLK_SEQ_ERR_EN: start in ON → single err pulse, en unchanged. Start and stop together in OFF → err pulse, state stays OFF.

Source files
------------

// File: rtl/clk_seq_ctrl.sv
// Staggered clock-enable sequencer: ramps generator enables up in ascending index
// order and down in descending order with a fixed gap. Optional err port via CLK_SEQ_ERR_EN.
module clk_seq_ctrl #(
  parameter int unsigned NUM_CLKS = 4,
  parameter int unsigned GAP      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_req,
  input  logic                stop_req,
  input  logic [NUM_CLKS-1:0] mask,
  output logic [NUM_CLKS-1:0] en,
  output logic                busy,
  output logic                done
`ifdef CLK_SEQ_ERR_EN
  ,
  output logic                err
`endif
);

  localparam int unsigned IW = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1;
  localparam int unsigned SW = IW + 1;
  localparam int unsigned CW = $clog2(GAP + 1);

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    RAMP_UP   = 2'd1,
    ON        = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [NUM_CLKS-1:0] act_mask, act_mask_nxt;
  logic [NUM_CLKS-1:0] en_nxt;
  logic [IW-1:0]       idx, idx_nxt;
  logic                idx_vld, idx_vld_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic                busy_nxt, done_nxt;

  // Scan results are {found, index}
  logic [SW-1:0] first_up, second_up, top_dn, second_dn, next_up, next_dn;

  // Lowest set bit of v at index >= floor
  function automatic logic [SW-1:0] scan_up(input logic [NUM_CLKS-1:0] v, input int floor);
    logic [SW-1:0] r;
    r = '0;
    for (int i = int'(NUM_CLKS) - 1; i >= 0; i--) begin
      if (v[i] && (i >= floor)) r = {1'b1, IW'(i)};
    end
    return r;
  endfunction

  // Highest set bit of v at index <= ceil
  function automatic logic [SW-1:0] scan_down(input logic [NUM_CLKS-1:0] v, input int ceil);
    logic [SW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(NUM_CLKS); i++) begin
      if (v[i] && (i <= ceil)) r = {1'b1, IW'(i)};
    end
    return r;
  endfunction

  assign first_up  = scan_up(mask, 0);
  assign second_up = scan_up(mask, int'(first_up[IW-1:0]) + 1);
  assign top_dn    = scan_down(en, int'(NUM_CLKS) - 1);
  assign second_dn = scan_down(en, int'(top_dn[IW-1:0]) - 1);
  assign next_up   = scan_up(act_mask, int'(idx) + 1);
  assign next_dn   = scan_down(en, int'(idx) - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= OFF;
      act_mask <= '0;
      en       <= '0;
      idx      <= '0;
      idx_vld  <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      act_mask <= act_mask_nxt;
      en       <= en_nxt;
      idx      <= idx_nxt;
      idx_vld  <= idx_vld_nxt;
      cnt      <= cnt_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  // idx/idx_vld hold the next bit still to be stepped; the first step happens on acceptance
  always_comb begin
    state_nxt    = state;
    act_mask_nxt = act_mask;
    en_nxt       = en;
    idx_nxt      = idx;
    idx_vld_nxt  = idx_vld;
    cnt_nxt      = cnt;
    done_nxt     = 1'b0;

    if (stop_req && ((state == RAMP_UP) || (state == ON))) begin
      state_nxt = RAMP_DOWN;
      if (top_dn[IW]) en_nxt[top_dn[IW-1:0]] = 1'b0;
      cnt_nxt     = CW'(GAP - 1);
      idx_nxt     = second_dn[IW-1:0];
      idx_vld_nxt = second_dn[IW];
    end else begin
      case (state)
        OFF: begin
          if (start_req && !stop_req) begin
            act_mask_nxt = mask;
            if (first_up[IW]) begin
              state_nxt                    = RAMP_UP;
              en_nxt[first_up[IW-1:0]]     = 1'b1;
              cnt_nxt                      = CW'(GAP - 1);
              idx_nxt                      = second_up[IW-1:0];
              idx_vld_nxt                  = second_up[IW];
            end else begin
              state_nxt = ON;
              done_nxt  = 1'b1;
            end
          end
        end
        RAMP_UP: begin
          if (!idx_vld) begin
            state_nxt = ON;
            done_nxt  = 1'b1;
          end else if (cnt == '0) begin
            en_nxt[idx] = 1'b1;
            cnt_nxt     = CW'(GAP - 1);
            idx_nxt     = next_up[IW-1:0];
            idx_vld_nxt = next_up[IW];
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        RAMP_DOWN: begin
          if (!idx_vld) begin
            state_nxt = OFF;
            done_nxt  = 1'b1;
          end else if (cnt == '0) begin
            en_nxt[idx] = 1'b0;
            cnt_nxt     = CW'(GAP - 1);
            idx_nxt     = next_dn[IW-1:0];
            idx_vld_nxt = next_dn[IW];
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        ON: begin
        end
        default: state_nxt = OFF;
      endcase
    end

    busy_nxt = (state_nxt == RAMP_UP) || (state_nxt == RAMP_DOWN);
  end

`ifdef CLK_SEQ_ERR_EN
  // A start loses to a simultaneous stop and is only accepted in OFF; stop is ignored in OFF/RAMP_DOWN
  logic drop;
  assign drop = (start_req && (stop_req || (state != OFF))) ||
                (stop_req && ((state == OFF) || (state == RAMP_DOWN)));

  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= drop;
  end
`endif

endmodule

// File: tb/tb_clk_seq_ctrl.sv
// Directed bench for clk_seq_ctrl (NUM_CLKS=4, GAP=8); err checks only with CLK_SEQ_ERR_EN.
module tb_clk_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_req;
  logic       stop_req;
  logic [3:0] mask;
  logic [3:0] en;
  logic       busy;
  logic       done;
`ifdef CLK_SEQ_ERR_EN
  logic       err;
`endif

  int total = 0;
  int bad   = 0;

  clk_seq_ctrl #(.NUM_CLKS(4), .GAP(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_req (start_req),
    .stop_req  (stop_req),
    .mask      (mask),
    .en        (en),
    .busy      (busy),
    .done      (done)
`ifdef CLK_SEQ_ERR_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_req = 1'b0; stop_req = 1'b0; mask = 4'b0000;
    tick(); tick();
    total++; if (en !== 4'b0000) begin bad++; $display("FAIL reset en: got %b want 0000", en); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", done); end
    rst = 1'b0;
    tick();
    total++; if (en !== 4'b0000 || busy !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset: got en=%b busy=%b want en=0000 busy=0", en, busy);
    end
  endtask

  task automatic test_full_up();
    logic [3:0] xe; logic xb, xd;
    mask = 4'b1111; start_req = 1'b1;
    for (int e = 1; e <= 27; e++) begin
      tick(); start_req = 1'b0;
      xe = {e >= 25, e >= 17, e >= 9, e >= 1};
      xb = (e <= 25);
      xd = (e == 26);
      total++; if (en !== xe) begin bad++; $display("FAIL full_up en edge %0d: got %b want %b", e, en, xe); end
      total++; if (busy !== xb) begin bad++; $display("FAIL full_up busy edge %0d: got %b want %b", e, busy, xb); end
      total++; if (done !== xd) begin bad++; $display("FAIL full_up done edge %0d: got %b want %b", e, done, xd); end
    end
  endtask

  // Stop and start together while ON: stop wins, ramp-down begins
  task automatic test_full_down();
    logic [3:0] xe; logic xb, xd;
    stop_req = 1'b1; start_req = 1'b1; mask = 4'b0001;
    for (int e = 1; e <= 27; e++) begin
      tick(); stop_req = 1'b0; start_req = 1'b0;
      xe = {e < 1, e < 9, e < 17, e < 25};
      xb = (e <= 25);
      xd = (e == 26);
      total++; if (en !== xe) begin bad++; $display("FAIL full_down en edge %0d: got %b want %b", e, en, xe); end
      total++; if (busy !== xb) begin bad++; $display("FAIL full_down busy edge %0d: got %b want %b", e, busy, xb); end
      total++; if (done !== xd) begin bad++; $display("FAIL full_down done edge %0d: got %b want %b", e, done, xd); end
    end
  endtask

  task automatic test_priority_off();
    mask = 4'b1111; start_req = 1'b1; stop_req = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      tick(); start_req = 1'b0; stop_req = 1'b0;
      total++; if (en !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
        bad++; $display("FAIL priority_off edge %0d: got en=%b busy=%b done=%b want 0000/0/0", e, en, busy, done);
      end
    end
  endtask

  // Sparse mask; mask changes after acceptance must be ignored
  task automatic test_sparse();
    logic [3:0] xe; logic xb, xd;
    mask = 4'b1010; start_req = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      tick(); start_req = 1'b0; mask = 4'b0101;
      xe = {e >= 9, 1'b0, 1'b1, 1'b0};
      xb = (e <= 9);
      xd = (e == 10);
      total++; if (en !== xe) begin bad++; $display("FAIL sparse_up en edge %0d: got %b want %b", e, en, xe); end
      total++; if (busy !== xb) begin bad++; $display("FAIL sparse_up busy edge %0d: got %b want %b", e, busy, xb); end
      total++; if (done !== xd) begin bad++; $display("FAIL sparse_up done edge %0d: got %b want %b", e, done, xd); end
    end
    stop_req = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      tick(); stop_req = 1'b0;
      xe = {1'b0, 1'b0, e < 9, 1'b0};
      xb = (e <= 9);
      xd = (e == 10);
      total++; if (en !== xe) begin bad++; $display("FAIL sparse_down en edge %0d: got %b want %b", e, en, xe); end
      total++; if (busy !== xb) begin bad++; $display("FAIL sparse_down busy edge %0d: got %b want %b", e, busy, xb); end
      total++; if (done !== xd) begin bad++; $display("FAIL sparse_down done edge %0d: got %b want %b", e, done, xd); end
    end
  endtask

  task automatic test_zero_mask();
    mask = 4'b0000; start_req = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      tick(); start_req = 1'b0;
      total++; if (en !== 4'b0000 || busy !== 1'b0) begin
        bad++; $display("FAIL zero_up edge %0d: got en=%b busy=%b want 0000/0", e, en, busy);
      end
      total++; if (done !== (e == 1)) begin bad++; $display("FAIL zero_up done edge %0d: got %b want %b", e, done, e == 1); end
    end
    stop_req = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick(); stop_req = 1'b0;
      total++; if (en !== 4'b0000) begin bad++; $display("FAIL zero_down en edge %0d: got %b want 0000", e, en); end
      total++; if (busy !== (e == 1)) begin bad++; $display("FAIL zero_down busy edge %0d: got %b want %b", e, busy, e == 1); end
      total++; if (done !== (e == 2)) begin bad++; $display("FAIL zero_down done edge %0d: got %b want %b", e, done, e == 2); end
    end
  endtask

  // Stop during ramp-up, sampled at edge 11 with en=0011
  task automatic test_abort();
    logic [3:0] xe; logic xb, xd;
    mask = 4'b1111; start_req = 1'b1;
    for (int e = 1; e <= 28; e++) begin
      tick(); start_req = 1'b0; stop_req = 1'b0;
      xe = {1'b0, 1'b0, (e >= 9) && (e <= 10), e < 19};
      xb = (e <= 19);
      xd = (e == 20);
      total++; if (en !== xe) begin bad++; $display("FAIL abort en edge %0d: got %b want %b", e, en, xe); end
      total++; if (busy !== xb) begin bad++; $display("FAIL abort busy edge %0d: got %b want %b", e, busy, xb); end
      total++; if (done !== xd) begin bad++; $display("FAIL abort done edge %0d: got %b want %b", e, done, xd); end
      if (e == 10) stop_req = 1'b1;
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] xe;
    mask = 4'b1111; start_req = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick(); start_req = 1'b0;
    end
    total++; if (en !== 4'b0011) begin bad++; $display("FAIL reset_mid pre en: got %b want 0011", en); end
    rst = 1'b1;
    tick(); rst = 1'b0;
    total++; if (en !== 4'b0000) begin bad++; $display("FAIL reset_mid en: got %b want 0000", en); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_mid busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_mid done: got %b want 0", done); end
    tick();
    total++; if (en !== 4'b0000 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid hold: got en=%b busy=%b want 0000/0", en, busy);
    end
    mask = 4'b0110; start_req = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      tick(); start_req = 1'b0;
      xe = {1'b0, e >= 9, 1'b1, 1'b0};
      total++; if (en !== xe) begin bad++; $display("FAIL restart en edge %0d: got %b want %b", e, en, xe); end
      total++; if (done !== (e == 10)) begin bad++; $display("FAIL restart done edge %0d: got %b want %b", e, done, e == 10); end
    end
  endtask

`ifdef CLK_SEQ_ERR_EN
  task automatic test_err();
    rst = 1'b1; tick(); rst = 1'b0;
    mask = 4'b0001; start_req = 1'b1; stop_req = 1'b1;
    tick(); start_req = 1'b0; stop_req = 1'b0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_both_off pulse: got %b want 1", err); end
    total++; if (en !== 4'b0000 || busy !== 1'b0) begin
      bad++; $display("FAIL err_both_off state: got en=%b busy=%b want 0000/0", en, busy);
    end
    tick();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_both_off clear: got %b want 0", err); end
    start_req = 1'b1;
    tick(); start_req = 1'b0;
    total++; if (err !== 1'b0 || en !== 4'b0001) begin
      bad++; $display("FAIL err_accept: got err=%b en=%b want 0/0001", err, en);
    end
    tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL err_on done: got %b want 1", done); end
    mask = 4'b1111; start_req = 1'b1;
    tick(); start_req = 1'b0;
    total++; if (err !== 1'b1 || en !== 4'b0001) begin
      bad++; $display("FAIL err_start_on: got err=%b en=%b want 1/0001", err, en);
    end
    tick();
    total++; if (err !== 1'b0 || en !== 4'b0001 || busy !== 1'b0) begin
      bad++; $display("FAIL err_start_on after: got err=%b en=%b busy=%b want 0/0001/0", err, en, busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_up();
    test_full_down();
    test_priority_off();
    test_sparse();
    test_zero_mask();
    test_abort();
    test_reset_mid();
`ifdef CLK_SEQ_ERR_EN
    test_err();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
